// File: rtl/compound_type_sink_pkg.sv
// testbasic17_types: CompoundType link payload, mode encoding and sink FSM states
package testbasic17_types;
  localparam int CT_X_W = 32;
  typedef enum logic {read = 1'b0, write = 1'b1} CompoundMode;
  typedef struct packed {
    CompoundMode mode;
    logic [CT_X_W-1:0] x;
    logic y;
  } CompoundType;
  typedef enum logic {SINK_IDLE, SINK_RESP} SinkSections;
endpackage

// File: rtl/compound_type_sink_acc_update.sv
// compound_acc_update: combinational next-accumulator for one CompoundType transaction
module compound_acc_update
  import testbasic17_types::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_acc,
  input  logic [DATA_W-1:0] i_x,
  input  logic              i_y,
  input  CompoundMode       i_mode,
  output logic [DATA_W-1:0] o_acc_next
);
  // anything other than write leaves the accumulator alone; y selects add vs load
  always_comb o_acc_next = (i_mode == write) ? (i_y ? i_acc + i_x : i_x) : i_acc;
endmodule

// File: rtl/compound_type_sink.sv
// compound_type_sink: accumulates CompoundType writes, answers reads on a blocking result port
module compound_type_sink
  import testbasic17_types::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  CompoundType       b_in,
  input  logic              b_in_sync,
  output logic              b_in_notify,
  output logic [DATA_W-1:0] r_out,
  input  logic              r_out_sync,
  output logic              r_out_notify,
  output logic [DATA_W-1:0] m_out,
  output logic [CNT_W-1:0]  txn_count
);
  SinkSections       r_state;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] w_acc_next;
  logic              w_b_xfer;
  logic              w_r_xfer;
  assign w_b_xfer = b_in_notify && b_in_sync;
  assign w_r_xfer = r_out_notify && r_out_sync;
  assign m_out    = r_acc;
  compound_acc_update #(.DATA_W(DATA_W)) u_upd (
    .i_acc      (r_acc),
    .i_x        (DATA_W'(b_in.x)),
    .i_y        (b_in.y),
    .i_mode     (b_in.mode),
    .o_acc_next (w_acc_next)
  );
  // sink FSM: accept writes/reads in IDLE, hold the response in RESP until taken
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= SINK_IDLE;
      r_acc        <= '0;
      r_out        <= '0;
      b_in_notify  <= 1'b1;
      r_out_notify <= 1'b0;
      txn_count    <= '0;
    end else if (r_state == SINK_IDLE) begin
      if (w_b_xfer) begin
        r_acc <= w_acc_next;
        if (txn_count != {CNT_W{1'b1}}) txn_count <= txn_count + 1'b1;
        if (b_in.mode != write) begin
          r_out        <= r_acc;
          b_in_notify  <= 1'b0;
          r_out_notify <= 1'b1;
          r_state      <= SINK_RESP;
        end
      end
    end else if (w_r_xfer) begin
      r_out_notify <= 1'b0;
      b_in_notify  <= 1'b1;
      r_state      <= SINK_IDLE;
    end
  end
endmodule
